// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, line record and flush FSM states for the AES output packer
package aes_pkg;
    localparam int DATA_W       = 128;
    localparam int LINE_W       = 512;
    localparam int BLK_PER_LINE = LINE_W / DATA_W;
    localparam int NBLK_W       = 3;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [NBLK_W-1:0] nblk;
    } line_t;

    typedef enum logic {ST_IDLE, ST_PEND} flush_st_t;
endpackage

// File: rtl/aes_line_fifo.sv
// aes_line_fifo: synchronous show-ahead FIFO of packed lines
module aes_line_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_push,
    input  line_t i_data,
    input  logic  i_pop,
    output line_t o_data,
    output logic  o_full,
    output logic  o_empty
);
    localparam int AW = $clog2(DEPTH);
    line_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/aes128_out_packer.sv
// aes128_out_packer: packs cipher blocks into 512-bit lines with block-granular credit flow control
module aes128_out_packer
    import aes_pkg::*;
#(
    parameter int FIFO_LINES = 16,
    parameter int CRED_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_in,
    output logic              issue_ok,
    input  logic              blk_valid_in,
    input  logic [DATA_W-1:0] blk_data_in,
    input  logic              flush_in,
    output logic              flush_done,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [LINE_W-1:0] line_data,
    output logic [2:0]        line_nblk,
    output logic              overflow_err
);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_LINES * BLK_PER_LINE);
    logic [CRED_W-1:0] r_credit;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_hold [3];
    flush_st_t         r_state;
    logic              r_done;
    logic              r_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_dec;
    logic              w_full_line;
    logic              w_req;
    logic              w_part;
    logic              w_fire;
    logic              w_done;
    logic [2:0]        w_k;
    logic [CRED_W-1:0] w_avail;
    logic [CRED_W-1:0] w_need;
    logic [LINE_W-1:0] w_line_data;
    line_t             w_line;
    line_t             w_head;
    assign issue_ok     = r_credit != '0;
    assign flush_done   = r_done;
    assign overflow_err = r_ovf;
    assign line_valid   = !w_empty;
    assign line_data    = w_head.data;
    assign line_nblk    = w_head.nblk;
    assign w_pop        = line_valid && line_ready;
    assign w_dec        = issue_in && issue_ok;
    assign w_full_line  = blk_valid_in && r_idx == 2'd3;
    // w_k counts blocks in the current line after packing this cycle's arrival
    assign w_k          = {1'b0, r_idx} + {2'b00, blk_valid_in};
    assign w_req        = r_state == ST_PEND || flush_in;
    assign w_avail      = r_credit - {{(CRED_W-1){1'b0}}, w_dec};
    assign w_need       = CRED_W'(3'd4 - w_k);
    assign w_part       = w_req && !w_full_line && w_k != 3'd0;
    assign w_fire       = w_part && w_avail >= w_need;
    assign w_done       = w_req && !(w_part && !w_fire);
    assign w_push       = w_full_line || w_fire;
    assign w_line       = {w_line_data, w_k};
    for (genvar s = 0; s < BLK_PER_LINE; s++) begin : g_slot
        logic [DATA_W-1:0] w_blk;
        if (s < 3) begin : g_held
            assign w_blk = (blk_valid_in && r_idx == 2'(s)) ? blk_data_in : r_hold[s];
        end else begin : g_last
            assign w_blk = blk_data_in;
        end
        assign w_line_data[s*DATA_W +: DATA_W] = 3'(s) < w_k ? w_blk : '0;
    end
    aes_line_fifo #(.DEPTH(FIFO_LINES)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_data (w_line),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= CRED_MAX;
            r_idx    <= '0;
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_credit <= r_credit - {{(CRED_W-1){1'b0}}, w_dec} - (w_fire ? w_need : '0)
                        + (w_pop ? CRED_W'(BLK_PER_LINE) : '0);
            r_idx    <= w_fire ? 2'd0 : r_idx + {1'b0, blk_valid_in};
            if (blk_valid_in && r_idx != 2'd3) r_hold[r_idx] <= blk_data_in;
            r_state  <= (w_req && !w_done) ? ST_PEND : ST_IDLE;
            r_done   <= w_done;
            r_ovf    <= r_ovf || (issue_in && !issue_ok) || (w_push && w_full)
                        || (flush_in && r_state == ST_PEND);
        end
    end
endmodule

// File: tb/tb_aes128_out_packer.sv
// tb_aes128_out_packer: vector table, directed corner sequences and random traffic against a queue model
module tb_aes128_out_packer;
    logic         clk = 1'b0;
    logic         reset;
    logic         issue_in;
    logic         issue_ok;
    logic         blk_valid_in;
    logic [127:0] blk_data_in;
    logic         flush_in;
    logic         flush_done;
    logic         line_valid;
    logic         line_ready;
    logic [511:0] line_data;
    logic [2:0]   line_nblk;
    logic         overflow_err;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes128_out_packer dut (
        .clk         (clk),
        .reset       (reset),
        .issue_in    (issue_in),
        .issue_ok    (issue_ok),
        .blk_valid_in(blk_valid_in),
        .blk_data_in (blk_data_in),
        .flush_in    (flush_in),
        .flush_done  (flush_done),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .line_data   (line_data),
        .line_nblk   (line_nblk),
        .overflow_err(overflow_err)
    );

    typedef struct {
        logic [511:0] data;
        int           nblk;
    } mline_t;

    mline_t       m_q[$];
    logic [127:0] m_part[$];
    int           m_credit;
    bit           m_pend;
    bit           m_done;
    bit           m_ovf;

    typedef struct {
        bit           iss;
        bit           blk;
        logic [127:0] d;
        bit           fl;
        bit           rdy;
        bit           ev;
        int           en;
        logic [511:0] ed;
        bit           edone;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pack(input logic [127:0] p[$]);
        logic [511:0] r = '0;
        foreach (p[i]) r[i*128 +: 128] = p[i];
        return r;
    endfunction

    function automatic logic [511:0] ln4(input logic [127:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic vec_t v(input bit iss, blk, input logic [127:0] d, input bit fl, rdy, ev,
                               input int en, input logic [511:0] ed, input bit edone);
        return '{iss, blk, d, fl, rdy, ev, en, ed, edone};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_part.delete();
        m_credit = 64;
        m_pend   = 0;
        m_done   = 0;
        m_ovf    = 0;
    endtask

    // Behaviour over one clock edge, from the state visible before that edge
    task automatic model_step(input bit iss, blk, input logic [127:0] d, input bit fl, rdy);
        bit     pop   = m_q.size() > 0 && rdy;
        bit     full  = m_q.size() == 16;
        int     dec   = (iss && m_credit > 0) ? 1 : 0;
        bit     pend  = m_pend || fl;
        bit     push  = 0;
        int     debit = 0;
        mline_t ln;
        if (iss && m_credit == 0) m_ovf = 1;
        if (fl && m_pend) m_ovf = 1;
        if (blk) m_part.push_back(d);
        m_done = 0;
        if (m_part.size() == 4 || (pend && m_part.size() > 0 && m_credit - dec >= 4 - m_part.size())) begin
            push    = 1;
            ln.data = pack(m_part);
            ln.nblk = m_part.size();
            debit   = 4 - m_part.size();
            m_part.delete();
        end
        if (pend && m_part.size() == 0) begin
            m_done = 1;
            pend   = 0;
        end
        m_pend = pend;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (full) m_ovf = 1;
            else m_q.push_back(ln);
        end
        m_credit = m_credit - dec - debit + (pop ? 4 : 0);
    endtask

    task automatic cmp_model();
        check("issue_ok", issue_ok, m_credit > 0);
        check("flush_done", flush_done, m_done);
        check("overflow_err", overflow_err, m_ovf);
        check("line_valid", line_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("line_data", line_data, m_q[0].data);
            check("line_nblk", line_nblk, m_q[0].nblk);
        end
    endtask

    task automatic cyc(input bit iss, blk, input logic [127:0] d, input bit fl, rdy);
        issue_in     = iss;
        blk_valid_in = blk;
        blk_data_in  = d;
        flush_in     = fl;
        line_ready   = rdy;
        model_step(iss, blk, d, fl, rdy);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        reset        = 1;
        issue_in     = 0;
        blk_valid_in = 0;
        blk_data_in  = '0;
        flush_in     = 0;
        line_ready   = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        cmp_model();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [127:0] a = 128'hA0A0;
        logic [127:0] b = 128'hB0B0;
        logic [127:0] c = 128'hC0C0;
        logic [127:0] e = 128'hD0D0;
        int  pops;
        bit  seen2;
        bit  got;
        bit  pipe_v[5];
        logic [127:0] pipe_d[5];

        tv.push_back(v(1, 1, 128'h1, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h2, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h3, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h4, 0, 1, 1, 4, ln4(128'h1, 128'h2, 128'h3, 128'h4), 0));
        tv.push_back(v(1, 1, 128'h5, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h6, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h7, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, 128'h8, 0, 1, 1, 4, ln4(128'h5, 128'h6, 128'h7, 128'h8), 0));
        tv.push_back(v(0, 0, '0, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, a, 0, 0, 0, 0, '0, 0));
        tv.push_back(v(1, 1, b, 0, 0, 0, 0, '0, 0));
        tv.push_back(v(1, 1, c, 0, 0, 0, 0, '0, 0));
        tv.push_back(v(0, 0, '0, 1, 0, 1, 3, ln4(a, b, c, '0), 1));
        tv.push_back(v(0, 0, '0, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(0, 0, '0, 1, 1, 0, 0, '0, 1));
        tv.push_back(v(0, 0, '0, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, a, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, b, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, c, 0, 1, 0, 0, '0, 0));
        tv.push_back(v(1, 1, e, 1, 1, 1, 4, ln4(a, b, c, e), 1));
        tv.push_back(v(0, 0, '0, 0, 1, 0, 0, '0, 0));

        do_reset();
        check("reset issue_ok", issue_ok, 1);
        check("reset line_valid", line_valid, 0);
        foreach (tv[i]) begin
            cyc(tv[i].iss, tv[i].blk, tv[i].d, tv[i].fl, tv[i].rdy);
            check($sformatf("tv%0d line_valid", i), line_valid, tv[i].ev);
            if (tv[i].ev) begin
                check($sformatf("tv%0d line_nblk", i), line_nblk, tv[i].en);
                check($sformatf("tv%0d line_data", i), line_data, tv[i].ed);
            end
            check($sformatf("tv%0d flush_done", i), flush_done, tv[i].edone);
        end

        // Fill every credit with the consumer stalled, then release one line
        do_reset();
        for (int i = 0; i < 64; i++) begin
            cyc(1, 1, rnd128(), 0, 0);
            if (i == 62) check("issue_ok before last credit", issue_ok, 1);
        end
        check("issue_ok after 64 issues", issue_ok, 0);
        check("no overflow when full", overflow_err, 0);
        check("line_valid when full", line_valid, 1);
        cyc(0, 0, '0, 0, 1);
        check("issue_ok after one pop", issue_ok, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, rnd128(), 0, 0);
        check("issue_ok after 4 more issues", issue_ok, 0);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (line_valid) pops++;
            cyc(0, 0, '0, 0, 1);
        end
        check("lines drained", pops, 16);
        check("issue_ok after drain", issue_ok, 1);

        // Partial flush waits for enough credit to cover the unused slots
        do_reset();
        for (int i = 0; i < 62; i++) cyc(1, 1, rnd128(), 0, 0);
        cyc(1, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 0);
        check("flush held for credit", flush_done, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0);
        check("flush still held", flush_done, 0);
        cyc(0, 0, '0, 0, 1);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            cyc(0, 0, '0, 0, 0);
            got = flush_done;
        end
        check("flush_done after pop", got, 1);
        cyc(0, 1, rnd128(), 0, 1);
        seen2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (line_valid && line_nblk == 3'd2) seen2 = 1;
            cyc(0, 0, '0, 0, 1);
        end
        check("partial line nblk 2 seen", seen2, 1);

        // Reset mid-stream drops queued lines
        for (int i = 0; i < 9; i++) cyc(1, 1, rnd128(), 0, 0);
        check("lines queued before reset", line_valid, 1);
        do_reset();
        check("line_valid after mid reset", line_valid, 0);
        check("issue_ok after mid reset", issue_ok, 1);

        // Random legal traffic through a 5-cycle core pipeline
        for (int i = 0; i < 5; i++) begin
            pipe_v[i] = 0;
            pipe_d[i] = '0;
        end
        for (int n = 0; n < 3000; n++) begin
            bit           iss = m_credit > 0 && $urandom_range(0, 3) != 0;
            bit           fl  = !m_pend && $urandom_range(0, 31) == 0;
            bit           rdy = $urandom_range(0, 1) == 1;
            bit           bv  = pipe_v[4];
            logic [127:0] bd  = pipe_d[4];
            for (int i = 4; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = iss;
            pipe_d[0] = rnd128();
            cyc(iss, bv, bd, fl, rdy);
        end
        for (int i = 4; i >= 0; i--) cyc(0, pipe_v[i], pipe_d[i], 0, 1);
        cyc(0, 0, '0, 1, 1);
        for (int i = 0; i < 40; i++) cyc(0, 0, '0, 0, 1);
        check("random drained", line_valid, 0);
        check("random credit restored", m_credit, 64);
        check("random no overflow", overflow_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes128_out_packer.md
Name: aes128_out_packer

Overview:
- Downstream of the AES-128 pipelined core; consumes its per-cycle `valid_out`/`cipher_text` stream.
- Packs consecutive 128-bit cipher blocks into 512-bit lines and buffers them in a line FIFO with a valid/ready output to the memory write path.
- The core cannot stall, so the block also runs a block-granular credit counter. Upstream may present a new plaintext only while `issue_ok` is high, so every in-flight block is guaranteed a FIFO slot.

Parameters:
- DATA_W, 128, cipher block width
- LINE_W, 512, output line width; BLK_PER_LINE = LINE_W/DATA_W = 4
- FIFO_LINES, 16, line FIFO depth (power of 2)
- CRED_W, 8, credit counter width; must hold FIFO_LINES*BLK_PER_LINE

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous to clk, active-high
- issue_in  in  1  upstream presents a block to the core this cycle (same cycle as the core's data_valid_in)
- issue_ok  out  1  credit > 0; upstream must not assert issue_in when low
- blk_valid_in  in  1  core valid_out
- blk_data_in  in  DATA_W  core cipher_text
- flush_in  in  1  single-cycle request: emit the partial line
- flush_done  out  1  one-cycle pulse when the flush has completed
- line_valid  out  1  line available
- line_ready  in  1  consumer accepts the line
- line_data  out  LINE_W  block k at bits [k*128+127 : k*128]
- line_nblk  out  3  valid blocks in line, 1..4
- overflow_err  out  1  sticky; a block arrived with no packing or FIFO space

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - credit = FIFO_LINES*4.
  - Packer count = 0; FIFO empty; flush_pend = 0.
  - All outputs are 0, except issue_ok = 1.
- Credit counter:
  - issue_in decrements credit by 1.
  - A line pop (line_valid & line_ready) adds 4.
  - Both events in the same cycle: net +3.
  - issue_in while credit = 0 is ignored for accounting and sets overflow_err.
- Packer:
  - 2-bit slot index plus a 3x128 holding register.
  - On blk_valid_in, the block is written to slot idx.
  - When idx = 3, the three held blocks plus the incoming block are pushed as one line with nblk = 4, and idx wraps to 0.
  - Push is registered. If the FIFO was empty, line_valid rises the cycle after the 4th block (latency 1).
- FIFO: show-ahead, registered outputs; line_data/line_nblk are stable while line_valid & !line_ready.
- Flush:
  - flush_in sets flush_pend.
  - A pending flush with idx = k > 0 requires credit >= 4-k, because a partial line occupies a full slot.
    - If satisfied: push the line with unused slots zero-filled and nblk = k, debit credit by 4-k, reset idx to 0, pulse flush_done, clear pend.
    - Otherwise hold pend until credit suffices.
  - A pending flush with idx = 0: pulse flush_done on the next cycle and push nothing.
- Simultaneous blk_valid_in and flush:
  - The arriving block is packed first, and the flush covers it.
  - If that block completes a line, the full-line push satisfies the flush.
  - flush_done still pulses.
- blk_valid_in while pend is held is legal: packing continues, and the flush still applies to the current partial line.
- FIFO full on push, or a second flush_in while pend: the push is illegal (cannot occur under correct credit use) and sets overflow_err; the FIFO is unchanged. The second flush is merged into the pending one.
- Mid-operation reset discards all packed and queued data. The core must be reset in the same cycle.

Decomposition:
- Shared package aes_pkg:
  - DATA_W and LINE_W constants.
  - BLK_PER_LINE.
  - A line struct of data plus nblk.
- One natural sub-module: aes_line_fifo (synchronous show-ahead FIFO of LINE_W+3 bits, push/pop/full/empty, synchronous active-high reset).
- The packer, credit counter and flush FSM (IDLE, PEND) stay in the top.

Test Plan:
- Reset, then 8 back-to-back blocks 0x01..0x08 with line_ready=1:
  - line 0 = {04,03,02,01} nblk=4, one cycle after block 4;
  - line 1 = {08..05};
  - credit returns to 64.
- line_ready=0 and issue 64 blocks:
  - issue_ok drops after the 64th issue;
  - FIFO holds 16 lines; no overflow_err;
  - one pop raises issue_ok with credit 4.
- 3 blocks A,B,C then flush_in:
  - line {0,C,B,A} nblk=3;
  - flush_done pulses once;
  - credit debited 4 in total for that line.
- flush_in with idx=0: flush_done the next cycle, no line, credit unchanged.
- flush_in coincident with the 4th block: exactly one line nblk=4 and one flush_done.
- Credit = 1 with 2 partial blocks, then flush: the flush waits until a pop, then emits nblk=2.
- Reset asserted mid-stream with lines queued: line_valid=0 and issue_ok=1 the cycle after reset.
